// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared memory bus between the CPU (requester 0) and NUM_REQ-1 bus masters.
// Optional macro CPU_PRIORITY_EN: the CPU always wins, the others round-robin among themselves.
module mem_bus_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [1:0]                fsm_state
);
  // Handshake: a requester holds valid/write/addr/wdata until its one-cycle req_ready;
  // grant stays one-hot from the latch edge through the DONE cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t           state, state_next;
  logic [IDX_W-1:0] last_grant, owner, winner;
  logic [3:0]       count;
  int               scan_idx;

  assign fsm_state = state;

  // Scan downward so the last hit is the nearest requester after last_grant.
  always_comb begin
    winner   = '0;
    scan_idx = 0;
`ifdef CPU_PRIORITY_EN
    for (int k = NUM_REQ - 1; k >= 1; k--) begin
      scan_idx = int'(last_grant) + k;
      if (scan_idx > NUM_REQ - 1) scan_idx = scan_idx - (NUM_REQ - 1);
      if (req_valid[scan_idx[IDX_W-1:0]]) winner = scan_idx[IDX_W-1:0];
    end
    if (req_valid[0]) winner = '0;
`else
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = int'(last_grant) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (req_valid[scan_idx[IDX_W-1:0]]) winner = scan_idx[IDX_W-1:0];
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req_valid) state_next = ACCESS;
      ACCESS:  if (count == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant      <= '0;
      req_ready  <= '0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      count      <= '0;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner     <= winner;
            grant     <= NUM_REQ'(1) << winner;
            mem_en    <= 1'b1;
            mem_we    <= req_write[winner];
            mem_addr  <= req_addr[winner*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[winner*DATA_W +: DATA_W];
            count     <= 4'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            if (!mem_we) rdata <= mem_rdata;
            req_ready <= grant;
`ifdef CPU_PRIORITY_EN
            // CPU grants leave the peripheral round-robin pointer untouched.
            if (owner != '0) last_grant <= owner;
`else
            last_grant <= owner;
`endif
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end
        end
        DONE: begin
          grant     <= '0;
          req_ready <= '0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
